// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU, memory request, compare/branch resolution
// and a fixed-latency multiplier that back-pressures decode through stall.
module execute_unit #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              isadd,
    input  logic              issub,
    input  logic              ismul,
    input  logic              isld,
    input  logic              isst,
    input  logic              iscmp,
    input  logic              ismov,
    input  logic              isor,
    input  logic              isand,
    input  logic              isnot,
    input  logic              islsl,
    input  logic              islsr,
    input  logic              isbeq,
    input  logic              isbgt,
    input  logic              isubranch,
    input  logic              iswb,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] st_data,
    input  logic [3:0]        rd,
    input  logic [PC_W-1:0]   branch_target,
    output logic              stall,
    output logic              is_branch_taken,
    output logic [PC_W-1:0]   branch_pc,
    output logic [DATA_W-1:0] result,
    output logic              wb_en,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              flag_eq,
    output logic              flag_gt,
    output logic              onehot_err,
    output logic              dbg_state
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [14:0]        ops;
    logic               sampled;
    logic               valid;
    logic               multi;
    logic               accept_mul;
    logic               mul_done;
    logic               alu_op;
    logic [DATA_W-1:0]  alu_val;
    logic               take_branch;
    logic [DATA_W-1:0]  mul_a;
    logic [DATA_W-1:0]  mul_b;
    logic [DATA_W-1:0]  mul_lo;
    logic               mul_wb;
    logic [3:0]         mul_rd;

    assign ops = {isadd, issub, ismul, isld, isst, iscmp, ismov, isor, isand,
                  isnot, islsl, islsr, isbeq, isbgt, isubranch};

    // Inputs are only looked at in IDLE and never in the squash cycle after a taken branch.
    assign sampled    = (state == IDLE) && !is_branch_taken;
    assign valid      = sampled && $onehot0(ops);
    assign multi      = sampled && !$onehot0(ops);
    assign accept_mul = valid && ismul;
    assign mul_done   = (state == MUL) && (cnt == '0);
    assign mul_lo     = mul_a * mul_b;

    // State register and multiply countdown
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept_mul) begin
                cnt <= CNT_W'(MUL_CYCLES - 2);
            end else if ((state == MUL) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_mul) state_next = MUL;
            MUL:  if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall     = accept_mul || ((state == MUL) && (cnt != '0));
        dbg_state = state;
    end

    always_comb begin
        alu_op  = isadd | issub | ismov | isor | isand | isnot | islsl | islsr;
        alu_val = '0;
        if (isadd) alu_val = op_a + op_b;
        if (issub) alu_val = op_a - op_b;
        if (ismov) alu_val = op_b;
        if (isor)  alu_val = op_a | op_b;
        if (isand) alu_val = op_a & op_b;
        if (isnot) alu_val = ~op_b;
        if (islsl) alu_val = op_a << op_b[SH_W-1:0];
        if (islsr) alu_val = op_a >> op_b[SH_W-1:0];
        take_branch = (isbeq && flag_eq) || (isbgt && flag_gt) || isubranch;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            is_branch_taken <= 1'b0;
            branch_pc       <= '0;
            result          <= '0;
            wb_en           <= 1'b0;
            wb_rd           <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_rd_en       <= 1'b0;
            mem_wr_en       <= 1'b0;
            flag_eq         <= 1'b0;
            flag_gt         <= 1'b0;
            onehot_err      <= 1'b0;
            mul_a           <= '0;
            mul_b           <= '0;
            mul_wb          <= 1'b0;
            mul_rd          <= '0;
        end else begin
            wb_en           <= 1'b0;
            mem_rd_en       <= 1'b0;
            mem_wr_en       <= 1'b0;
            is_branch_taken <= 1'b0;
            if (multi) onehot_err <= 1'b1;
            if (valid) begin
                if (alu_op) begin
                    result <= alu_val;
                    wb_en  <= iswb;
                    wb_rd  <= rd;
                end
                if (isld) begin
                    mem_addr  <= op_a + op_b;
                    mem_rd_en <= 1'b1;
                    wb_rd     <= rd;
                end
                if (isst) begin
                    mem_addr  <= op_a + op_b;
                    mem_wdata <= st_data;
                    mem_wr_en <= 1'b1;
                end
                if (iscmp) begin
                    flag_eq <= (op_a == op_b);
                    flag_gt <= ($signed(op_a) > $signed(op_b));
                end
                if (take_branch) begin
                    is_branch_taken <= 1'b1;
                    branch_pc       <= branch_target;
                end
                if (ismul) begin
                    mul_a  <= op_a;
                    mul_b  <= op_b;
                    mul_wb <= iswb;
                    mul_rd <= rd;
                end
            end
            if (mul_done) begin
                result <= mul_lo;
                wb_en  <= mul_wb;
                wb_rd  <= mul_rd;
            end
        end
    end
endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU ops, memory requests, multiply stall,
// branch/squash behaviour, reset during multiply and the one-hot error flag.
module tb_execute_unit;
    localparam int DW = 32;
    localparam int PW = 32;
    localparam int MC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          isadd, issub, ismul, isld, isst, iscmp, ismov, isor, isand;
    logic          isnot, islsl, islsr, isbeq, isbgt, isubranch, iswb;
    logic [DW-1:0] op_a, op_b, st_data;
    logic [3:0]    rd;
    logic [PW-1:0] branch_target;
    logic          stall, is_branch_taken, wb_en, mem_rd_en, mem_wr_en;
    logic          flag_eq, flag_gt, onehot_err, dbg_state;
    logic [PW-1:0] branch_pc;
    logic [DW-1:0] result, mem_addr, mem_wdata;
    logic [3:0]    wb_rd;

    int checks = 0;
    int fails  = 0;

    execute_unit #(.DATA_W(DW), .PC_W(PW), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset),
        .isadd(isadd), .issub(issub), .ismul(ismul), .isld(isld), .isst(isst),
        .iscmp(iscmp), .ismov(ismov), .isor(isor), .isand(isand), .isnot(isnot),
        .islsl(islsl), .islsr(islsr), .isbeq(isbeq), .isbgt(isbgt),
        .isubranch(isubranch), .iswb(iswb),
        .op_a(op_a), .op_b(op_b), .st_data(st_data), .rd(rd),
        .branch_target(branch_target),
        .stall(stall), .is_branch_taken(is_branch_taken), .branch_pc(branch_pc),
        .result(result), .wb_en(wb_en), .wb_rd(wb_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .flag_eq(flag_eq), .flag_gt(flag_gt), .onehot_err(onehot_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {isadd, issub, ismul, isld, isst, iscmp, ismov, isor, isand} = '0;
        {isnot, islsl, islsr, isbeq, isbgt, isubranch, iswb} = '0;
        op_a = '0; op_b = '0; st_data = '0; rd = '0; branch_target = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({result, mem_addr, mem_wdata, branch_pc} !== '0) begin
            fails++; $display("FAIL reset_data: got %h/%h/%h/%h want all 0", result, mem_addr, mem_wdata, branch_pc);
        end
        checks++;
        if ({stall, is_branch_taken, wb_en, mem_rd_en, mem_wr_en, flag_eq, flag_gt, onehot_err, dbg_state, wb_rd} !== '0) begin
            fails++; $display("FAIL reset_ctrl: stall=%b br=%b wb=%b rd=%b wr=%b eq=%b gt=%b err=%b st=%b want 0",
                stall, is_branch_taken, wb_en, mem_rd_en, mem_wr_en, flag_eq, flag_gt, onehot_err, dbg_state);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu();
        clear_inputs(); isadd = 1; iswb = 1; op_a = 5; op_b = 7; rd = 4'd3;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL add_stall: got %b want 0", stall); end
        step();
        checks++;
        if (result !== 32'd12 || wb_en !== 1'b1 || wb_rd !== 4'd3) begin
            fails++; $display("FAIL add: result=%h wb_en=%b wb_rd=%0d want 0000000c 1 3", result, wb_en, wb_rd);
        end
        // back-to-back: sub immediately after add
        clear_inputs(); issub = 1; iswb = 1; op_a = 3; op_b = 5; rd = 4'd7;
        step();
        checks++;
        if (result !== 32'hFFFF_FFFE || wb_en !== 1'b1 || wb_rd !== 4'd7) begin
            fails++; $display("FAIL sub: result=%h wb_en=%b wb_rd=%0d want fffffffe 1 7", result, wb_en, wb_rd);
        end
        clear_inputs(); islsl = 1; op_a = 1; op_b = 33;
        step();
        checks++;
        if (result !== 32'd2 || wb_en !== 1'b0) begin
            fails++; $display("FAIL lsl: result=%h wb_en=%b want 00000002 0", result, wb_en);
        end
        clear_inputs(); islsr = 1; iswb = 1; op_a = 32'h8000_0000; op_b = 31;
        step();
        checks++;
        if (result !== 32'd1) begin fails++; $display("FAIL lsr: got %h want 00000001", result); end
        clear_inputs(); isand = 1; iswb = 1; op_a = 32'hF0F0_1234; op_b = 32'h0FF0_FF00;
        step();
        checks++;
        if (result !== 32'h00F0_1200) begin fails++; $display("FAIL and: got %h want 00f01200", result); end
        clear_inputs(); isor = 1; iswb = 1; op_a = 32'hF000_0001; op_b = 32'h0000_0F00;
        step();
        checks++;
        if (result !== 32'hF000_0F01) begin fails++; $display("FAIL or: got %h want f0000f01", result); end
        clear_inputs(); isnot = 1; iswb = 1; op_b = 32'h0000_FFFF;
        step();
        checks++;
        if (result !== 32'hFFFF_0000) begin fails++; $display("FAIL not: got %h want ffff0000", result); end
        clear_inputs(); ismov = 1; iswb = 1; op_a = 32'h1; op_b = 32'hCAFE_BABE;
        step();
        checks++;
        if (result !== 32'hCAFE_BABE) begin fails++; $display("FAIL mov: got %h want cafebabe", result); end
        clear_inputs();
        step();
        checks++;
        if (wb_en !== 1'b0) begin fails++; $display("FAIL wb_pulse: got %b want 0", wb_en); end
    endtask

    task automatic test_mem();
        clear_inputs(); isld = 1; iswb = 1; op_a = 32'h100; op_b = 32'h10; rd = 4'd5;
        step();
        checks++;
        if (mem_addr !== 32'h110 || mem_rd_en !== 1'b1 || wb_en !== 1'b0 || wb_rd !== 4'd5 || mem_wr_en !== 1'b0) begin
            fails++; $display("FAIL ld: addr=%h rd_en=%b wb_en=%b wb_rd=%0d wr_en=%b want 110 1 0 5 0",
                mem_addr, mem_rd_en, wb_en, wb_rd, mem_wr_en);
        end
        clear_inputs(); isst = 1; op_a = 32'h200; op_b = 32'h4; st_data = 32'hDEAD_BEEF;
        step();
        checks++;
        if (mem_addr !== 32'h204 || mem_wdata !== 32'hDEAD_BEEF || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || wb_en !== 1'b0) begin
            fails++; $display("FAIL st: addr=%h wdata=%h wr_en=%b rd_en=%b wb_en=%b want 204 deadbeef 1 0 0",
                mem_addr, mem_wdata, mem_wr_en, mem_rd_en, wb_en);
        end
        clear_inputs();
        step();
        checks++;
        if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL st_pulse: got %b want 0", mem_wr_en); end
    endtask

    task automatic test_mul();
        int stall_cycles = 0;
        int wb_pulses = 0;
        int wb_edge = -1;
        logic [DW-1:0] wb_val = '0;
        clear_inputs(); ismul = 1; iswb = 1; op_a = 6; op_b = 7; rd = 4'd9;
        for (int i = 0; i < 10; i++) begin
            if (i == MC) clear_inputs();
            if (stall === 1'b1) stall_cycles++;
            step();
            if (wb_en === 1'b1) begin
                wb_pulses++; wb_edge = i + 1; wb_val = result;
                checks++;
                if (wb_rd !== 4'd9) begin fails++; $display("FAIL mul_rd: got %0d want 9", wb_rd); end
            end
        end
        checks++;
        if (stall_cycles != MC - 1) begin fails++; $display("FAIL mul_stall: got %0d cycles want %0d", stall_cycles, MC - 1); end
        checks++;
        if (wb_pulses != 1 || wb_edge != MC) begin
            fails++; $display("FAIL mul_wb: pulses=%0d edge=%0d want 1 at %0d", wb_pulses, wb_edge, MC);
        end
        checks++;
        if (wb_val !== 32'd42) begin fails++; $display("FAIL mul_result: got %h want 0000002a", wb_val); end
    endtask

    task automatic test_branch();
        clear_inputs(); iscmp = 1; op_a = 9; op_b = 9;
        step();
        checks++;
        if (flag_eq !== 1'b1 || flag_gt !== 1'b0) begin fails++; $display("FAIL cmp_eq: eq=%b gt=%b want 1 0", flag_eq, flag_gt); end
        clear_inputs(); isbeq = 1; branch_target = 32'h40;
        step();
        checks++;
        if (is_branch_taken !== 1'b1 || branch_pc !== 32'h40) begin
            fails++; $display("FAIL beq: taken=%b pc=%h want 1 00000040", is_branch_taken, branch_pc);
        end
        clear_inputs(); isadd = 1; iswb = 1; op_a = 1; op_b = 1; rd = 4'd1;
        step();
        checks++;
        if (wb_en !== 1'b0 || is_branch_taken !== 1'b0 || result === 32'd2) begin
            fails++; $display("FAIL squash: wb_en=%b taken=%b result=%h want 0 0 not-2", wb_en, is_branch_taken, result);
        end
        clear_inputs(); iscmp = 1; op_a = 32'hFFFF_FFFF; op_b = 1;
        step();
        checks++;
        if (flag_gt !== 1'b0 || flag_eq !== 1'b0) begin fails++; $display("FAIL cmp_neg: eq=%b gt=%b want 0 0", flag_eq, flag_gt); end
        clear_inputs(); isbgt = 1; branch_target = 32'h80;
        step();
        checks++;
        if (is_branch_taken !== 1'b0) begin fails++; $display("FAIL bgt_not: taken=%b want 0", is_branch_taken); end
        clear_inputs(); isubranch = 1; branch_target = 32'h1234;
        step();
        checks++;
        if (is_branch_taken !== 1'b1 || branch_pc !== 32'h1234) begin
            fails++; $display("FAIL ubranch: taken=%b pc=%h want 1 00001234", is_branch_taken, branch_pc);
        end
        clear_inputs();
        step();
        clear_inputs(); iscmp = 1; op_a = 5; op_b = 32'hFFFF_FFFD;
        step();
        clear_inputs(); isbgt = 1; branch_target = 32'h88;
        step();
        checks++;
        if (is_branch_taken !== 1'b1 || branch_pc !== 32'h88 || flag_gt !== 1'b1) begin
            fails++; $display("FAIL bgt_taken: taken=%b pc=%h gt=%b want 1 00000088 1", is_branch_taken, branch_pc, flag_gt);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_mul();
        int late_wb = 0;
        clear_inputs(); ismul = 1; iswb = 1; op_a = 3; op_b = 4; rd = 4'd2;
        step();
        step();
        checks++;
        if (dbg_state !== 1'b1 || stall !== 1'b1) begin fails++; $display("FAIL mid_mul_state: st=%b stall=%b want 1 1", dbg_state, stall); end
        reset = 1'b0;
        clear_inputs();
        step();
        checks++;
        if (dbg_state !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0 || flag_gt !== 1'b0 || result !== '0 || wb_rd !== '0) begin
            fails++; $display("FAIL mul_reset: st=%b stall=%b wb=%b gt=%b result=%h wb_rd=%0d want all 0",
                dbg_state, stall, wb_en, flag_gt, result, wb_rd);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wb_en !== 1'b0) late_wb++;
        end
        checks++;
        if (late_wb != 0) begin fails++; $display("FAIL mul_reset_wb: got %0d pulses want 0", late_wb); end
    endtask

    task automatic test_onehot();
        clear_inputs(); isadd = 1; issub = 1; iswb = 1; op_a = 8; op_b = 1;
        step();
        checks++;
        if (onehot_err !== 1'b1 || wb_en !== 1'b0) begin fails++; $display("FAIL onehot: err=%b wb_en=%b want 1 0", onehot_err, wb_en); end
        clear_inputs(); isadd = 1; iswb = 1; op_a = 2; op_b = 2;
        step();
        checks++;
        if (onehot_err !== 1'b1 || result !== 32'd4 || wb_en !== 1'b1) begin
            fails++; $display("FAIL onehot_sticky: err=%b result=%h wb_en=%b want 1 00000004 1", onehot_err, result, wb_en);
        end
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (onehot_err !== 1'b0) begin fails++; $display("FAIL onehot_clear: got %b want 0", onehot_err); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu();
        test_mem();
        test_mul();
        test_branch();
        test_reset_mid_mul();
        test_onehot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the pipeline, sitting downstream of the decode-stage control unit. It consumes the one-hot operation strobes (`isadd` … `isubranch`, `iswb`) plus operands and produces the ALU result, memory request and writeback strobes. It runs the multi-cycle multiplier and back-pressures decode through `stall`. It resolves branches against its compare flags and drives `is_branch_taken` back to fetch/decode.

## Interface
- `DATA_W`, 32, operand/result width; power of two, ≥8.
- `PC_W`, 32, branch target width.
- `MUL_CYCLES`, 4, multiply latency in cycles; ≥2.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low (`reset==0` at a rising edge resets).
- `isadd, issub, ismul, isld, isst, iscmp, ismov, isor, isand, isnot, islsl, islsr, isbeq, isbgt, isubranch`  in  1 each  operation strobes; at most one high; all low = bubble.
- `iswb`  in  1  instruction writes a register.
- `op_a, op_b`  in  DATA_W  source operands.
- `st_data`  in  DATA_W  store data.
- `rd`  in  4  destination register index.
- `branch_target`  in  PC_W  target for beq/bgt/ubranch.
- `stall`  out  1  combinational; decode holds its outputs while high.
- `is_branch_taken`  out  1  registered one-cycle pulse.
- `branch_pc`  out  PC_W  registered; valid with `is_branch_taken`.
- `result`  out  DATA_W  registered ALU result.
- `wb_en`  out  1  registered one-cycle writeback strobe.
- `wb_rd`  out  4  registered destination; valid with `wb_en`.
- `mem_addr`, `mem_wdata`  out  DATA_W  registered memory request.
- `mem_rd_en`, `mem_wr_en`  out  1  registered one-cycle strobes.
- `flag_eq`, `flag_gt`  out  1  compare flags.
- `onehot_err`  out  1  sticky protocol error.

## Operation
- Reset: all outputs 0, FSM `IDLE`, counter 0, flags 0, `onehot_err` 0.
- FSM `IDLE`/`MUL`. Inputs are sampled only in `IDLE` and only when `is_branch_taken==0` (squash cycle); otherwise they are ignored.
- In `IDLE`, a sampled instruction registers its result at the same edge: add `a+b`, sub `a-b` (mod 2^DATA_W), and/or/not (`~op_b`), mov (`op_b`), lsl/lsr logical by `op_b[log2(DATA_W)-1:0]`. `wb_en=iswb`, `wb_rd=rd`.
- ld: `mem_addr=op_a+op_b`, `mem_rd_en=1`, `wb_rd=rd`, `wb_en=0` (memory stage writes back). st: `mem_addr=op_a+op_b`, `mem_wdata=st_data`, `mem_wr_en=1`, `wb_en=0`.
- cmp: `flag_eq=(op_a==op_b)`, `flag_gt=($signed(op_a)>$signed(op_b))`. Flags hold until the next cmp.
- beq taken iff `flag_eq`; bgt iff `flag_gt`; ubranch always. Flags are the values registered before this cycle. Taken: `is_branch_taken=1`, `branch_pc=branch_target` for one cycle. Not taken: nothing.
- mul: latch operands, counter ← `MUL_CYCLES-2`, go `MUL`. In `MUL` the counter decrements each cycle. At the edge where counter==0: `result` = low DATA_W bits of `op_a*op_b`, `wb_en=iswb` latched at acceptance, `wb_rd` latched `rd`, return `IDLE`.
- `stall = (IDLE && ismul && sampled) || (MUL && counter!=0)`.
- More than one strobe high while sampling: treat as bubble, set `onehot_err` (sticky until reset).
- Single-cycle strobes (`wb_en`, `mem_*_en`, `is_branch_taken`) return to 0 the cycle after assertion unless re-triggered.

## Timing
- Single-cycle ops: outputs valid 1 edge after sampling.
- mul: `stall` high exactly `MUL_CYCLES-1` cycles, starting in the accept cycle. Result/`wb_en` at edge `MUL_CYCLES` counted from the accept cycle. Upstream presents the next instruction in the cycle after `stall` falls.
- The cycle after a taken branch is a squash cycle: inputs ignored, no outputs.
- Reset mid-`MUL`: next edge → `IDLE`, `stall` 0, no `wb_en`, flags cleared.
- cmp immediately followed by beq uses the new flags, since the flags are registered at the cmp edge.

## Test plan
- add `5,7` → next edge `result=12`, `wb_en=1` one cycle. sub `3,5` → `0xFFFFFFFE`.
- mul `6,7` held during stall, `MUL_CYCLES=4` → `stall` high 3 cycles. `result=42`, single `wb_en` pulse at 4th edge. No restart from the held strobe.
- cmp `9,9`, then beq target `0x40`, then add → `is_branch_taken` one cycle, `branch_pc=0x40`. The add is squashed (no `wb_en`).
- cmp `0xFFFFFFFF,1` then bgt → `flag_gt=0`, no branch. ubranch → taken.
- `reset=0` during 2nd `MUL` cycle → next edge all outputs 0, `stall=0`, no writeback.
- `isadd&issub` together → `onehot_err=1`, no `wb_en`, stays 1 through later valid ops until reset. lsl `1` by `33` → `2`. lsr `0x80000000` by `31` → `1`.
